// File: rtl/csr_pkg.sv
// -----------------------------------------------------------------------------
// csr_pkg
// Shared definitions for the CSR write queue slice.
//   CSR_WIDTH_DEFAULT      : default CSR data width in bits
//   CSR_ADDR_WIDTH_DEFAULT : default CSR address width in bits
//   csr_entry_t            : queue entry {addr, data} at the default widths;
//                            also the default entry type of csr_queue_mem
// -----------------------------------------------------------------------------
package csr_pkg;

  localparam int CSR_WIDTH_DEFAULT      = 32;
  localparam int CSR_ADDR_WIDTH_DEFAULT = 4;

  typedef struct packed {
    logic [CSR_ADDR_WIDTH_DEFAULT-1:0] addr;
    logic [CSR_WIDTH_DEFAULT-1:0]      data;
  } csr_entry_t;

endpackage : csr_pkg

// File: rtl/csr_queue_mem.sv
// -----------------------------------------------------------------------------
// csr_queue_mem
// Circular queue storage, read/write pointers and occupancy counter for the
// CSR write queue. The caller guarantees push only when not full and pop only
// when not empty.
//
// Parameters
//   DEPTH   : number of entries, power of two (2..16)
//   entry_t : packed entry type stored per slot
//
// Ports
//   clk, rst       : rising-edge clock, asynchronous active-high reset
//   push           : write push_entry at the tail
//   push_entry     : entry to enqueue
//   pop            : advance the head
//   head_entry     : entry at the head (valid when level != 0)
//   level          : current occupancy, 0..DEPTH
//   tail_wr        : (CSR_WRITE_QUEUE_COALESCE_EN only) overwrite tail slot
//   tail_entry_new : (CSR_WRITE_QUEUE_COALESCE_EN only) replacement tail entry
//   tail_entry     : (CSR_WRITE_QUEUE_COALESCE_EN only) most recently pushed
//
// Build option: `define CSR_WRITE_QUEUE_COALESCE_EN adds the tail ports.
// -----------------------------------------------------------------------------
module csr_queue_mem
  import csr_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = csr_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  entry_t                 push_entry,
  input  logic                   pop,
  output entry_t                 head_entry,
`ifdef CSR_WRITE_QUEUE_COALESCE_EN
  input  logic                   tail_wr,
  input  entry_t                 tail_entry_new,
  output entry_t                 tail_entry,
`endif
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  entry_t mem [DEPTH];

  // NOTE: storage has no reset; a slot is only observed once level says it
  // holds a pushed entry, so clearing it would add reset fan-out for nothing.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_entry;
    end
`ifdef CSR_WRITE_QUEUE_COALESCE_EN
    // Never concurrent with push: a coalescing write does not allocate.
    if (tail_wr) begin
      mem[wr_ptr - 1'b1] <= tail_entry_new;
    end
`endif
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      // Pointers are exactly log2(DEPTH) bits, so they wrap modulo DEPTH.
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign head_entry = mem[rd_ptr];

`ifdef CSR_WRITE_QUEUE_COALESCE_EN
  assign tail_entry = mem[wr_ptr - 1'b1];
`endif

endmodule : csr_queue_mem

// File: rtl/csr_write_queue.sv
// -----------------------------------------------------------------------------
// csr_write_queue
// Posted CSR write buffer. Each accepted write updates a local shadow register
// bank (for immediate readback) and is queued toward a slower target that
// drains entries with a strobe/ready handshake.
//
// Parameters
//   WIDTH       : CSR data width
//   ADDR_WIDTH  : CSR address width, 2**ADDR_WIDTH shadow registers
//   DEPTH       : queue entries, power of two (2..16)
//   RESET_VALUE : reset value of every shadow register
//
// Ports
//   clk, rst              : rising-edge clock, asynchronous active-high reset
//   wr_strobe/addr/data   : write request from the CSR master
//   wr_wait               : write presented this cycle is not accepted
//   tgt_strobe/addr/data  : head entry toward the target
//   tgt_ready             : target takes the head entry this cycle
//   rd_addr / rd_data     : combinational shadow readback
//   level                 : current queue occupancy
//
// Build option: `define CSR_WRITE_QUEUE_COALESCE_EN merges a write to the same
// address as the tail entry into that entry (only when tail is not head).
// -----------------------------------------------------------------------------
module csr_write_queue
  import csr_pkg::*;
#(
  parameter int               WIDTH       = CSR_WIDTH_DEFAULT,
  parameter int               ADDR_WIDTH  = CSR_ADDR_WIDTH_DEFAULT,
  parameter int               DEPTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_strobe,
  input  logic [ADDR_WIDTH-1:0]  wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  output logic                   wr_wait,
  output logic                   tgt_strobe,
  output logic [ADDR_WIDTH-1:0]  tgt_addr,
  output logic [WIDTH-1:0]       tgt_data,
  input  logic                   tgt_ready,
  input  logic [ADDR_WIDTH-1:0]  rd_addr,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] level
);

  localparam int NREG  = 2 ** ADDR_WIDTH;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      data;
  } entry_t;

  entry_t head_entry;
  entry_t new_entry;
  logic   full;
  logic   accept;
  logic   push;
  logic   pop;

  assign new_entry = '{addr: wr_addr, data: wr_data};
  assign full      = (level == LVL_W'(DEPTH));

  // ---------------------------------------------------------------------------
  // Write acceptance / optional coalescing
  // ---------------------------------------------------------------------------
`ifdef CSR_WRITE_QUEUE_COALESCE_EN
  entry_t tail_entry;
  logic   coal_hit;
  logic   tail_wr;

  // level >= 2 keeps the tail distinct from the head, so an entry the target
  // may be sampling this cycle is never modified underneath it.
  assign coal_hit = wr_strobe && (level >= LVL_W'(2)) && (tail_entry.addr == wr_addr);
  assign wr_wait  = full && !coal_hit;
  assign accept   = wr_strobe && !wr_wait;
  assign push     = accept && !coal_hit;
  assign tail_wr  = accept && coal_hit;
`else
  // A pop in the same cycle does not free a slot for the push: wr_wait
  // depends on registered level only, keeping tgt_ready off the wr_wait path.
  assign wr_wait  = full;
  assign accept   = wr_strobe && !wr_wait;
  assign push     = accept;
`endif

  // tgt_ready while empty has no effect.
  assign pop = tgt_strobe && tgt_ready;

  // ---------------------------------------------------------------------------
  // Queue storage
  // ---------------------------------------------------------------------------
  csr_queue_mem #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_queue_mem (
    .clk            (clk),
    .rst            (rst),
    .push           (push),
    .push_entry     (new_entry),
    .pop            (pop),
    .head_entry     (head_entry),
`ifdef CSR_WRITE_QUEUE_COALESCE_EN
    .tail_wr        (tail_wr),
    .tail_entry_new (new_entry),
    .tail_entry     (tail_entry),
`endif
    .level          (level)
  );

  // Head is presented straight from storage: one cycle of latency, no bypass.
  assign tgt_strobe = (level != '0);
  assign tgt_addr   = head_entry.addr;
  assign tgt_data   = head_entry.data;

  // ---------------------------------------------------------------------------
  // Shadow register bank
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] shadow [NREG];

  // Shadow contents are architecturally visible through rd_data, so unlike
  // the queue slots every register returns to RESET_VALUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        shadow[i] <= RESET_VALUE;
      end
    end else if (accept) begin
      shadow[wr_addr] <= wr_data;
    end
  end

  assign rd_data = shadow[rd_addr];

endmodule : csr_write_queue

// File: tb/tb_csr_write_queue.sv
// -----------------------------------------------------------------------------
// tb_csr_write_queue
// Self-checking bench for csr_write_queue. The stimulus side decides from a
// queue-of-entries model whether each write is accepted and appends it to the
// expected queue; a negedge monitor compares the DUT head, level, wr_wait and
// readback against that model and retires entries on each transfer.
// Honors `define CSR_WRITE_QUEUE_COALESCE_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_csr_write_queue;

  localparam int               WIDTH = 32;
  localparam int               AW    = 4;
  localparam int               DEPTH = 4;
  localparam int               NREG  = 2 ** AW;
  localparam int               LW    = $clog2(DEPTH) + 1;
  localparam logic [WIDTH-1:0] RV    = 32'h0BAD_F00D;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_strobe;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             wr_wait;
  logic             tgt_strobe;
  logic [AW-1:0]    tgt_addr;
  logic [WIDTH-1:0] tgt_data;
  logic             tgt_ready;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic [LW-1:0]    level;

  always #5 clk = ~clk;

  csr_write_queue #(
    .WIDTH       (WIDTH),
    .ADDR_WIDTH  (AW),
    .DEPTH       (DEPTH),
    .RESET_VALUE (RV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_strobe  (wr_strobe),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_wait    (wr_wait),
    .tgt_strobe (tgt_strobe),
    .tgt_addr   (tgt_addr),
    .tgt_data   (tgt_data),
    .tgt_ready  (tgt_ready),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .level      (level)
  );

  typedef struct {
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t             exp_q[$];
  logic [WIDTH-1:0] shadow_m [NREG];
  int               n_cmp  = 0;
  int               n_bad  = 0;
  int               n_xfer = 0;
  bit               mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // A write merges into the youngest queued entry when it targets the same
  // address and that entry is not the one being offered to the target.
  function automatic bit exp_coal_hit();
`ifdef CSR_WRITE_QUEUE_COALESCE_EN
    return wr_strobe && (exp_q.size() >= 2) && (exp_q[exp_q.size()-1].addr == wr_addr);
`else
    return 1'b0;
`endif
  endfunction

  // Monitor: outputs are stable mid-cycle; a transfer retires the model head.
  always @(negedge clk) begin : monitor
    exp_t head;
    bit   exp_wait;
    if (mon_en && !rst) begin
      exp_wait = (exp_q.size() == DEPTH) && !exp_coal_hit();
      check("level", 64'(level), 64'(exp_q.size()));
      check("tgt_strobe", 64'(tgt_strobe), 64'(exp_q.size() != 0));
      check("wr_wait", 64'(wr_wait), 64'(exp_wait));
      check("rd_data", 64'(rd_data), 64'(shadow_m[rd_addr]));
      if (exp_q.size() != 0) begin
        head = exp_q[0];
        check("tgt_addr", 64'(tgt_addr), 64'(head.addr));
        check("tgt_data", 64'(tgt_data), 64'(head.data));
        if (tgt_ready) begin
          void'(exp_q.pop_front());
          n_xfer++;
        end
      end
    end
  end

  // One clock of stimulus, entered and left just after a rising edge.
  task automatic cycle(input logic s, input logic [AW-1:0] a, input logic [WIDTH-1:0] d,
                       input logic r, input logic [AW-1:0] ra);
    bit   hit;
    bit   acc;
    exp_t e;
    wr_strobe = s;
    wr_addr   = a;
    wr_data   = d;
    tgt_ready = r;
    rd_addr   = ra;
    hit = exp_coal_hit();
    acc = s && !((exp_q.size() == DEPTH) && !hit);
    @(posedge clk);
    if (acc) begin
      shadow_m[a] = d;
      if (hit) begin
        e      = exp_q[exp_q.size()-1];
        e.data = d;
        exp_q[exp_q.size()-1] = e;
      end else begin
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
      end
    end
    #1;
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < NREG; i++) shadow_m[i] = RV;
  endtask

  // Asynchronous reset pulse, applied wherever the queue happens to be.
  task automatic do_reset();
    wr_strobe = 1'b0;
    rst       = 1'b1;
    model_reset();
    #1;
    check("rst_level", 64'(level), 64'd0);
    check("rst_strobe", 64'(tgt_strobe), 64'd0);
    check("rst_wait", 64'(wr_wait), 64'd0);
    for (int i = 0; i < NREG; i++) begin
      rd_addr = AW'(i);
      #1;
      check("rst_shadow", 64'(rd_data), 64'(RV));
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] a;
    rst       = 1'b1;
    wr_strobe = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    tgt_ready = 1'b0;
    rd_addr   = '0;
    model_reset();
    #2;
    check("init_level", 64'(level), 64'd0);
    check("init_strobe", 64'(tgt_strobe), 64'd0);
    check("init_wait", 64'(wr_wait), 64'd0);
    check("init_rd", 64'(rd_data), 64'(RV));
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    // Single write, target ready: visible one cycle later, popped that edge.
    cycle(1'b1, 4'd3, 32'hDEAD_BEEF, 1'b1, 4'd3);
    check("lat_strobe", 64'(tgt_strobe), 64'd1);
    check("lat_addr", 64'(tgt_addr), 64'd3);
    check("lat_data", 64'(tgt_data), 64'hDEAD_BEEF);
    check("lat_rd", 64'(rd_data), 64'hDEAD_BEEF);
    cycle(1'b0, 4'd0, '0, 1'b1, 4'd3);
    check("lat_popped", 64'(level), 64'd0);

    // Five writes into a stalled target: the fifth is refused.
    for (int i = 0; i < 5; i++) cycle(1'b1, AW'(4 + i), $urandom, 1'b0, 4'd4);
    check("full_level", 64'(level), 64'(DEPTH));
    check("full_wait", 64'(wr_wait), 64'd1);

    // Full with simultaneous push and pop: push refused, one entry leaves.
    cycle(1'b1, 4'd9, $urandom, 1'b1, 4'd9);
    check("full_pushpop_level", 64'(level), 64'(DEPTH - 1));
    check("full_pushpop_rd", 64'(rd_data), 64'(RV));
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 4'd0, '0, 1'b1, AW'(i));
    check("drain_level", 64'(level), 64'd0);

    // Same-address back-to-back writes behind an older entry.
    cycle(1'b1, 4'd2, 32'h11, 1'b0, 4'd5);
    cycle(1'b1, 4'd5, 32'h22, 1'b0, 4'd5);
    cycle(1'b1, 4'd5, 32'h33, 1'b0, 4'd5);
`ifdef CSR_WRITE_QUEUE_COALESCE_EN
    check("coal_level", 64'(level), 64'd2);
`else
    check("nocoal_level", 64'(level), 64'd3);
`endif
    check("coal_rd", 64'(rd_data), 64'h33);
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 4'd0, '0, 1'b1, 4'd5);

    // Three entries queued, target about to take them, then reset.
    for (int i = 0; i < 3; i++) cycle(1'b1, AW'(i), $urandom, 1'b0, 4'd0);
    check("pre_rst_level", 64'(level), 64'd3);
    tgt_ready = 1'b1;
    do_reset();
    cycle(1'b0, 4'd0, '0, 1'b1, 4'd0);
    check("post_rst_strobe", 64'(tgt_strobe), 64'd0);

    // Randomised traffic; narrow address range makes same-address runs common.
    for (int n = 0; n < 3000; n++) begin
      a = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 2));
      cycle($urandom_range(0, 9) < 7, a, $urandom, $urandom_range(0, 1) == 1, AW'($urandom));
      if (n == 1500) do_reset();
    end
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 4'd0, '0, 1'b1, AW'(i));
    check("final_level", 64'(level), 64'd0);
    check("xfer_seen", 64'(n_xfer > 100), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_csr_write_queue

// File: doc/csr_write_queue.md
CSR_WRITE_QUEUE -- requirements
Module: csr_write_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 32: CSR data width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4: CSR address width; 2**ADDR_WIDTH shadow registers.
REQ-003 SHALL have parameter DEPTH, default 4: queue entries; power of two, 2..16.
REQ-004 SHALL have parameter RESET_VALUE, default {WIDTH{1'b0}}: reset value of every shadow register.
REQ-005 SHALL have port clk  in  1: the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst  in  1: asynchronous, active-high reset.
REQ-007 SHALL have port wr_strobe  in  1: write request from the CSR master.
REQ-008 SHALL have port wr_addr  in  ADDR_WIDTH: write address.
REQ-009 SHALL have port wr_data  in  WIDTH: write data.
REQ-010 SHALL have port wr_wait  out  1: high means a write presented this cycle is not accepted.
REQ-011 SHALL have port tgt_strobe  out  1: head entry valid toward the target.
REQ-012 SHALL have ports tgt_addr  out  ADDR_WIDTH and tgt_data  out  WIDTH: head entry contents.
REQ-013 SHALL have port tgt_ready  in  1: target accepts the head entry this cycle.
REQ-014 SHALL have port rd_addr  in  ADDR_WIDTH: shadow readback address.
REQ-015 SHALL have port rd_data  out  WIDTH: shadow readback data.
REQ-016 SHALL have port level  out  $clog2(DEPTH)+1: current queue occupancy.

Function
REQ-017 A write SHALL be accepted when wr_strobe=1 and wr_wait=0 in the same cycle.
REQ-018 An accepted write SHALL update shadow[wr_addr] at that clock edge and enqueue {wr_addr,wr_data} at the tail.
REQ-019 rd_data SHALL be a combinational read of shadow[rd_addr]; a same-cycle write becomes visible the following cycle.
REQ-020 tgt_strobe SHALL equal (level!=0); tgt_addr/tgt_data SHALL present the head entry.
REQ-021 A transfer SHALL occur when tgt_strobe=1 and tgt_ready=1; the head pops at that edge.
REQ-022 While tgt_strobe=1 and tgt_ready=0, tgt_addr/tgt_data SHALL hold stable.
REQ-023 Latency SHALL be one cycle: a write accepted into an empty queue asserts tgt_strobe on the next cycle; there is no combinational bypass.
REQ-024 Without coalescing, wr_wait SHALL equal (level==DEPTH); a same-cycle pop does not unblock a push.
REQ-025 A simultaneous push and pop SHALL leave level unchanged; pointers wrap modulo DEPTH.
REQ-026 tgt_ready while level==0 SHALL be ignored.

Reset
REQ-027 On rst: level=0, pointers=0, tgt_strobe=0, wr_wait=0, every shadow register=RESET_VALUE.
REQ-028 Assertion mid-transfer SHALL discard all queued entries; no partial transfer is presented after release.

Configuration
REQ-029 Macro CSR_WRITE_QUEUE_COALESCE_EN defined: an accepted write whose address equals the tail entry's address SHALL overwrite that entry's data without allocating, provided level>=2 (tail is not head).
REQ-030 With the macro defined, wr_wait SHALL equal (level==DEPTH) and not coalesce-hit; a full queue accepts a coalescing write.
REQ-031 Macro undefined: every accepted write allocates an entry; no address compare logic is synthesised.

Structure
REQ-032 Package csr_pkg SHALL hold CSR_WIDTH_DEFAULT, CSR_ADDR_WIDTH_DEFAULT and the queue entry type {addr,data}.
REQ-033 Queue storage and pointers SHALL be sub-module csr_queue_mem; shadow bank, coalesce and handshake logic remain in csr_write_queue.

Verification
REQ-034 Reset then write addr 3 data 0xDEADBEEF with tgt_ready=1 -> next cycle tgt_strobe=1, tgt_addr=3, tgt_data=0xDEADBEEF; popped that edge; rd_data(3)=0xDEADBEEF.
REQ-035 tgt_ready=0, 5 writes with DEPTH=4 -> 4 accepted, wr_wait=1 on the 5th, level=4; tgt_ready=1 drains in order.
REQ-036 Full queue, simultaneous push and pop -> push rejected, level 4 to 3.
REQ-037 COALESCE_EN, tgt_ready=0, writes (2,0x11),(5,0x22),(5,0x33) -> level=2, second entry data 0x33.
REQ-038 Queue holding 3 entries, rst pulsed -> tgt_strobe=0, level=0, all shadow reads return RESET_VALUE.
